sumador_acumulador_param: RTL and testbench
===========================================

# sumador_acumulador_param

Parametrised, two-stage pipelined unsigned adder/subtractor with an internal accumulator, selectable wrap or saturate arithmetic, valid handshake, clock-enable stall and a result counter. It is the next generation of the team's 4-bit registered adder and drops into the same test harness: the bench drives `a`, `b` and `enb`, and checks `c`. It adds width, mode and pipeline control on top of that harness.

## Interface

Parameters:
- `WIDTH`, 4: operand and result width in bits.
- `SAT`, 0: 0 means results wrap modulo 2^WIDTH; 1 means results saturate.
- `CNT_W`, 8: width of the result counter.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `enb`  in  1: pipeline enable. 0 means the whole pipeline stalls.
- `valid_in`  in  1: the current `a`, `b` and `mode` form a request.
- `mode`  in  2: 00 is a+b, 01 is a−b, 10 is acc+a (accumulate), 11 clears acc.
- `a`  in  WIDTH: operand A, unsigned.
- `b`  in  WIDTH: operand B, unsigned; ignored in modes 10 and 11.
- `c`  out  WIDTH: registered result.
- `carry`  out  1: carry-out (modes 00, 10) or borrow (mode 01) of this result.
- `valid_out`  out  1: `c` and `carry` hold a new result this cycle.
- `acc`  out  WIDTH: current accumulator value.
- `count`  out  CNT_W: number of results produced since reset.

## Operation

Reset:
- While `rst_n`=0, all registers clear to 0. This covers S1 regs, `c`, `carry`, `valid_out`, `acc` and `count`.
- Reset is asynchronous: outputs go to 0 immediately, without waiting for a clock edge.

Stage 1 (S1), on an edge with `enb`=1:
- Capture `a`, `b`, `mode` and `valid_in` into s1 registers.

Stage 2 (S2), on an edge with `enb`=1 and s1_valid=1:
- Compute the full WIDTH+1-bit result r for s1_mode.
- Mode 00: r = a + b. `carry` = r[WIDTH].
- Mode 01: r = a − b. `carry` = (a < b).
- Mode 10: r = acc + a. `carry` = r[WIDTH]. `acc` ← c_next.
- Mode 11: c_next = 0, `carry` = 0, `acc` ← 0.
- With SAT=0, c_next = r[WIDTH-1:0].
- With SAT=1:
  - If `carry`=1 in mode 00 or 10, c_next = all ones.
  - If `carry`=1 in mode 01, c_next = 0.
  - Otherwise c_next = r[WIDTH-1:0].
- `carry` reports overflow/borrow regardless of the SAT setting.
- Register updates: `c` ← c_next, `valid_out` ← 1, `count` ← `count`+1.
- `count` wraps from 2^CNT_W−1 to 0.

S2, on an edge with `enb`=1 and s1_valid=0:
- `valid_out` ← 0.
- `c`, `carry`, `acc` and `count` hold.

Stall (`enb`=0):
- All registers hold, including `valid_out`.
- A held `valid_out`=1 is not a new result and is not counted again.

`acc` is only modified by modes 10 and 11. Modes 00 and 01 leave it untouched.

## Timing

Latency:
- A request sampled at rising edge k (`enb`=1, `valid_in`=1) appears on `c`/`valid_out` after edge k+1.
- This assumes `enb`=1 at edge k+1. Each edge with `enb`=0 adds one cycle of latency.

Throughput:
- One request per enabled cycle.
- Back-to-back accumulates chain correctly, because the `acc` feedback lives entirely in S2.
- `acc` output reflects the update in the same cycle as the corresponding `valid_out`.

Mixed requests:
- A mode-00/01 request between two accumulates does not disturb `acc`.

Reset mid-operation:
- In-flight S1/S2 contents are discarded.
- The first `valid_out` after release is the first request sampled after release, 2 enabled edges later.

`valid_in`=0 cycles create bubbles: `valid_out`=0 at the matching output cycle.

## Test plan

All scenarios use WIDTH=4 and CNT_W=8.

- Reset:
  - Assert `rst_n`=0 between clock edges → `c`, `carry`, `valid_out`, `acc` and `count` go to 0 without waiting for an edge.
  - Release reset, idle → all stay 0.
- Basic add:
  - (0,1) then (5,2) at consecutive edges, mode 00 → `c`=1 then `c`=7, `carry`=0, `valid_out`=1 for 2 cycles, `count`=2.
- Overflow/borrow:
  - Mode 00, 12+7 → SAT=0: `c`=3, `carry`=1. SAT=1: `c`=15, `carry`=1.
  - Mode 01, 3−5 → SAT=0: `c`=14, `carry`=1. SAT=1: `c`=0, `carry`=1.
- Accumulate:
  - Mode 11, then four back-to-back mode 10 requests with `a`=6.
  - SAT=0 → `c`/`acc`=6, 12, 2 (`carry`=1), 8.
  - SAT=1 → 6, 12, 15 (`carry`=1), 15 (`carry`=1).
  - Then mode 00 (1+1) → `c`=2, `acc` unchanged.
- Stall and bubble:
  - Drop `enb` for 3 cycles mid-stream → `c`, `valid_out` and `count` frozen, no duplicate count.
  - A `valid_in`=0 gap produces exactly one `valid_out`=0 cycle.
- Reset mid-stream and counter wrap:
  - Assert `rst_n` with 2 requests in flight → neither appears after release.
  - 256 requests → `count` wraps to 0.

Source files
------------

// File: rtl/sumador_acumulador_param.sv
// Two-stage pipelined unsigned adder/subtractor with accumulator, wrap/saturate
// arithmetic, clock-enable stall and a wrapping result counter.
module sumador_acumulador_param #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SAT   = 0,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enb,
  input  logic             valid_in,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             carry,
  output logic             valid_out,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned RW = WIDTH + 1;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } op_e;

  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_e              s1_mode;
  logic             s1_valid;

  logic [RW-1:0]    sum_c;
  logic             carry_c;
  logic [WIDTH-1:0] res_c;
  logic [WIDTH-1:0] acc_next_c;

  // Stage 1: request capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a     <= '0;
      s1_b     <= '0;
      s1_mode  <= OP_ADD;
      s1_valid <= 1'b0;
    end else if (enb) begin
      s1_a     <= a;
      s1_b     <= b;
      s1_mode  <= op_e'(mode);
      s1_valid <= valid_in;
    end
  end

  // Full-width arithmetic; the extra bit holds carry-out or the borrow wrap
  always_comb begin
    sum_c   = '0;
    carry_c = 1'b0;
    case (s1_mode)
      OP_ADD: begin
        sum_c   = RW'(s1_a) + RW'(s1_b);
        carry_c = sum_c[WIDTH];
      end
      OP_SUB: begin
        sum_c   = RW'(s1_a) - RW'(s1_b);
        carry_c = (s1_a < s1_b);
      end
      OP_ACC: begin
        sum_c   = RW'(acc) + RW'(s1_a);
        carry_c = sum_c[WIDTH];
      end
      default: begin
        sum_c   = '0;
        carry_c = 1'b0;
      end
    endcase
  end

  // Saturation clamps to all-ones on overflow and to zero on borrow
  always_comb begin
    res_c = sum_c[WIDTH-1:0];
    if ((SAT != 0) && carry_c) begin
      res_c = (s1_mode == OP_SUB) ? '0 : '1;
    end
  end

  always_comb begin
    acc_next_c = acc;
    case (s1_mode)
      OP_ACC:  acc_next_c = res_c;
      OP_CLR:  acc_next_c = '0;
      default: acc_next_c = acc;
    endcase
  end

  // Stage 2: result, accumulator and counter; a stall freezes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c         <= '0;
      carry     <= 1'b0;
      valid_out <= 1'b0;
      acc       <= '0;
      count     <= '0;
    end else if (enb) begin
      valid_out <= s1_valid;
      if (s1_valid) begin
        c     <= res_c;
        carry <= carry_c;
        acc   <= acc_next_c;
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sumador_acumulador_param.sv
// Bench for sumador_acumulador_param: wrap (SAT=0) and saturating (SAT=1)
// instances share stimulus; a queue scoreboard predicts every output cycle.
module tb_sumador_acumulador_param;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enb = 1'b0;
  logic          valid_in = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;

  logic [W-1:0]  c0, acc0, c1, acc1;
  logic          carry0, vo0, carry1, vo1;
  logic [CW-1:0] count0, count1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] c0;
    logic       cy0;
    logic [3:0] acc0;
    logic [3:0] c1;
    logic       cy1;
    logic [3:0] acc1;
  } exp_t;

  exp_t sb[$];

  // push-side accumulator predictions and output-side expected register state
  logic [3:0] pacc0, pacc1;
  logic [3:0] mc0, macc0, mc1, macc1;
  logic       mcy0, mcy1, mvo, ms1v;
  logic [7:0] mcount;

  sumador_acumulador_param #(.WIDTH(W), .SAT(0), .CNT_W(CW)) dut0 (
    .clk(clk), .rst_n(rst_n), .enb(enb), .valid_in(valid_in), .mode(mode),
    .a(a), .b(b), .c(c0), .carry(carry0), .valid_out(vo0), .acc(acc0), .count(count0)
  );

  sumador_acumulador_param #(.WIDTH(W), .SAT(1), .CNT_W(CW)) dut1 (
    .clk(clk), .rst_n(rst_n), .enb(enb), .valid_in(valid_in), .mode(mode),
    .a(a), .b(b), .c(c1), .carry(carry1), .valid_out(vo1), .acc(acc1), .count(count1)
  );

  always #5 clk = ~clk;

  function automatic void calc(input int sat, input logic [1:0] md, input logic [3:0] x,
                               input logic [3:0] y, input logic [3:0] ai,
                               output logic [3:0] co, output logic cy, output logic [3:0] ao);
    logic [4:0] r;
    case (md)
      2'd0:    r = {1'b0, x} + {1'b0, y};
      2'd1:    r = {1'b0, x} - {1'b0, y};
      2'd2:    r = {1'b0, ai} + {1'b0, x};
      default: r = 5'd0;
    endcase
    cy = (md == 2'd1) ? (x < y) : (md == 2'd3) ? 1'b0 : r[4];
    co = r[3:0];
    if (sat != 0 && cy) co = (md == 2'd1) ? 4'd0 : 4'd15;
    ao = (md == 2'd2) ? co : (md == 2'd3) ? 4'd0 : ai;
  endfunction

  task automatic reset_model();
    sb.delete();
    pacc0 = '0; pacc1 = '0;
    mc0 = '0; macc0 = '0; mc1 = '0; macc1 = '0;
    mcy0 = 1'b0; mcy1 = 1'b0; mvo = 1'b0; ms1v = 1'b0;
    mcount = '0;
  endtask

  // One clock: drive, push prediction, advance model, compare both instances
  task automatic step(input logic en, input logic vin, input logic [1:0] md,
                      input logic [3:0] x, input logic [3:0] y);
    exp_t e;
    enb = en; valid_in = vin; mode = md; a = x; b = y;
    if (en && vin) begin
      calc(0, md, x, y, pacc0, e.c0, e.cy0, e.acc0);
      calc(1, md, x, y, pacc1, e.c1, e.cy1, e.acc1);
      pacc0 = e.acc0;
      pacc1 = e.acc1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (en) begin
      mvo  = ms1v;
      ms1v = vin;
      if (mvo && sb.size() != 0) begin
        e = sb.pop_front();
        mc0 = e.c0; mcy0 = e.cy0; macc0 = e.acc0;
        mc1 = e.c1; mcy1 = e.cy1; macc1 = e.acc1;
        mcount = mcount + 8'd1;
      end
    end
    checks++;
    if ({vo0, c0, carry0, acc0, count0} !== {mvo, mc0, mcy0, macc0, mcount}) begin
      errors++;
      $display("FAIL step_sat0 @%0t: got vo=%0b c=%0d cy=%0b acc=%0d cnt=%0d, expected vo=%0b c=%0d cy=%0b acc=%0d cnt=%0d",
               $time, vo0, c0, carry0, acc0, count0, mvo, mc0, mcy0, macc0, mcount);
    end
    checks++;
    if ({vo1, c1, carry1, acc1, count1} !== {mvo, mc1, mcy1, macc1, mcount}) begin
      errors++;
      $display("FAIL step_sat1 @%0t: got vo=%0b c=%0d cy=%0b acc=%0d cnt=%0d, expected vo=%0b c=%0d cy=%0b acc=%0d cnt=%0d",
               $time, vo1, c1, carry1, acc1, count1, mvo, mc1, mcy1, macc1, mcount);
    end
  endtask

  task automatic do_reset();
    enb = 1'b0; valid_in = 1'b0;
    rst_n = 1'b0;
    #1;
    reset_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_model();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 1, 2'd0, 4'd9, 4'd9);
    step(1, 1, 2'd2, 4'd3, 4'd4);
    step(1, 1, 2'd0, 4'd1, 4'd2);
    // asynchronous assertion: outputs must clear mid-cycle
    rst_n = 1'b0;
    #2;
    checks++;
    if ({c0, carry0, vo0, acc0, count0, c1, carry1, vo1, acc1, count1} !== '0) begin
      errors++;
      $display("FAIL async_reset: got c=%0d cy=%0b vo=%0b acc=%0d cnt=%0d / c=%0d cy=%0b vo=%0b acc=%0d cnt=%0d, expected all 0",
               c0, carry0, vo0, acc0, count0, c1, carry1, vo1, acc1, count1);
    end
    reset_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) step(1, 0, 2'd0, 4'd0, 4'd0);
  endtask

  task automatic test_basic_add();
    step(1, 1, 2'd0, 4'd0, 4'd1);
    step(1, 1, 2'd0, 4'd5, 4'd2);
    checks++;
    if (c0 !== 4'd1 || vo0 !== 1'b1) begin
      errors++;
      $display("FAIL basic_first: got c=%0d vo=%0b, expected c=1 vo=1", c0, vo0);
    end
    step(1, 0, 2'd0, 4'd0, 4'd0);
    checks++;
    if (c0 !== 4'd7 || carry0 !== 1'b0 || vo0 !== 1'b1 || count0 !== 8'd2) begin
      errors++;
      $display("FAIL basic_second: got c=%0d cy=%0b vo=%0b cnt=%0d, expected c=7 cy=0 vo=1 cnt=2",
               c0, carry0, vo0, count0);
    end
    step(1, 0, 2'd0, 4'd0, 4'd0);
  endtask

  task automatic test_overflow();
    step(1, 1, 2'd0, 4'd12, 4'd7);
    step(1, 1, 2'd1, 4'd3, 4'd5);
    checks++;
    if ({c0, carry0, c1, carry1} !== {4'd3, 1'b1, 4'd15, 1'b1}) begin
      errors++;
      $display("FAIL add_overflow: got wrap c=%0d cy=%0b sat c=%0d cy=%0b, expected 3/1 15/1",
               c0, carry0, c1, carry1);
    end
    step(1, 0, 2'd0, 4'd0, 4'd0);
    checks++;
    if ({c0, carry0, c1, carry1} !== {4'd14, 1'b1, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL sub_borrow: got wrap c=%0d cy=%0b sat c=%0d cy=%0b, expected 14/1 0/1",
               c0, carry0, c1, carry1);
    end
  endtask

  task automatic test_accumulate();
    logic [3:0] seen0[4];
    logic [3:0] seen1[4];
    step(1, 1, 2'd3, 4'd0, 4'd0);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 2'd2, 4'd6, 4'd9);
      if (i > 0) begin
        seen0[i-1] = acc0;
        seen1[i-1] = acc1;
      end
    end
    step(1, 1, 2'd0, 4'd1, 4'd1);
    seen0[3] = acc0;
    seen1[3] = acc1;
    checks++;
    if ({seen0[0], seen0[1], seen0[2], seen0[3]} !== {4'd6, 4'd12, 4'd2, 4'd8}) begin
      errors++;
      $display("FAIL acc_wrap_seq: got %0d %0d %0d %0d, expected 6 12 2 8",
               seen0[0], seen0[1], seen0[2], seen0[3]);
    end
    checks++;
    if ({seen1[0], seen1[1], seen1[2], seen1[3]} !== {4'd6, 4'd12, 4'd15, 4'd15}) begin
      errors++;
      $display("FAIL acc_sat_seq: got %0d %0d %0d %0d, expected 6 12 15 15",
               seen1[0], seen1[1], seen1[2], seen1[3]);
    end
    step(1, 0, 2'd0, 4'd0, 4'd0);
    checks++;
    if ({c0, acc0, acc1} !== {4'd2, 4'd8, 4'd15}) begin
      errors++;
      $display("FAIL add_keeps_acc: got c=%0d acc_wrap=%0d acc_sat=%0d, expected c=2 acc 8/15",
               c0, acc0, acc1);
    end
  endtask

  task automatic test_stall_bubble();
    logic [2:0] vo_pat;
    step(1, 1, 2'd0, 4'd2, 4'd3);
    step(1, 1, 2'd0, 4'd4, 4'd4);
    repeat (3) step(0, 1, 2'd0, 4'd7, 4'd7);
    step(1, 0, 2'd0, 4'd0, 4'd0);
    step(1, 0, 2'd0, 4'd0, 4'd0);
    step(1, 1, 2'd0, 4'd1, 4'd2);
    step(1, 0, 2'd0, 4'd0, 4'd0);
    vo_pat[2] = vo0;
    step(1, 1, 2'd0, 4'd3, 4'd3);
    vo_pat[1] = vo0;
    step(1, 0, 2'd0, 4'd0, 4'd0);
    vo_pat[0] = vo0;
    checks++;
    if (vo_pat !== 3'b101) begin
      errors++;
      $display("FAIL bubble_pattern: got %b, expected 101", vo_pat);
    end
    step(1, 0, 2'd0, 4'd0, 4'd0);
  endtask

  task automatic test_reset_midstream();
    step(1, 1, 2'd0, 4'd5, 4'd5);
    step(1, 1, 2'd2, 4'd3, 4'd0);
    step(1, 1, 2'd0, 4'd6, 4'd1);
    do_reset();
    repeat (3) step(1, 0, 2'd0, 4'd0, 4'd0);
    step(1, 1, 2'd0, 4'd2, 4'd2);
    step(1, 0, 2'd0, 4'd0, 4'd0);
    checks++;
    if ({vo0, c0, count0, acc0} !== {1'b1, 4'd4, 8'd1, 4'd0}) begin
      errors++;
      $display("FAIL post_reset_first: got vo=%0b c=%0d cnt=%0d acc=%0d, expected vo=1 c=4 cnt=1 acc=0",
               vo0, c0, count0, acc0);
    end
  endtask

  task automatic test_count_wrap();
    do_reset();
    for (int i = 0; i < 256; i++) begin
      step(1, 1, 2'(i % 3), 4'(i), 4'(i >> 4));
    end
    checks++;
    if (count0 !== 8'd255) begin
      errors++;
      $display("FAIL count_255: got %0d, expected 255", count0);
    end
    step(1, 0, 2'd0, 4'd0, 4'd0);
    checks++;
    if (count0 !== 8'd0 || count1 !== 8'd0) begin
      errors++;
      $display("FAIL count_wrap: got %0d/%0d, expected 0", count0, count1);
    end
    step(1, 0, 2'd0, 4'd0, 4'd0);
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_overflow();
    test_accumulate();
    test_stall_bubble();
    test_reset_midstream();
    test_count_wrap();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
